instr_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the 9-bit processor datapath. Owns the program counter, fetches from the registered instruction ROM, and presents one latched instruction at a time to the ALU and register file. Also issues the register-write strobe and the PC update, including branches, and stops on a halt opcode. It sits between the instruction ROM and the fetch/ALU/reg_file datapath and replaces free-running `codeInput` feeding.

---
 rtl/instr_sequencer.sv | 126 ++++++++++++
 tb/tb_instr_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: owns the PC, fetches from a registered ROM,
// holds one instruction in IR through EXEC/WB, and stops on the halt opcode.
package isa_defs_pkg;
  localparam logic [4:0] kADD = 5'h01;
  localparam logic [4:0] kAND = 5'h02;
  localparam logic [4:0] kMOV = 5'h03;
  localparam logic [4:0] kSUB = 5'h04;
  localparam logic [4:0] kOR  = 5'h05;
  localparam logic [4:0] kBRH = 5'h0A;
endpackage

module instr_sequencer
  import isa_defs_pkg::*;
#(
  parameter int         PC_W    = 8,
  parameter logic [4:0] HALT_OP = 5'b11111,
  parameter int         CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [PC_W-1:0]  START_ADDRESS,
  input  logic [8:0]       INSTR,
  output logic             IMEM_RD,
  output logic [PC_W-1:0]  PC,
  output logic [8:0]       IR,
  input  logic             STALL,
  input  logic             BRANCH_TAKEN,
  input  logic [PC_W-1:0]  TARGET,
  output logic             REG_WR_EN,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] CYCLE_COUNT,
  output logic [CNT_W-1:0] INSTR_COUNT
);

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, EXEC, WB, HALTED} state_t;

  state_t           state, state_nxt;
  logic [PC_W-1:0]  pc_q, tgt_q;
  logic [8:0]       ir_q;
  logic             br_q;
  logic [CNT_W-1:0] cyc_q, ins_q;
  logic             start_ok;
  logic             is_brh;
  logic             busy;

  assign start_ok = START && (state == IDLE || state == HALTED);
  assign is_brh   = (ir_q[8:4] == kBRH);

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    IMEM_RD   = 1'b0;
    REG_WR_EN = 1'b0;
    busy      = 1'b0;
    DONE      = 1'b0;
    case (state)
      IDLE: begin
        if (START) state_nxt = FETCH;
      end
      FETCH: begin
        IMEM_RD   = 1'b1;
        busy      = 1'b1;
        state_nxt = LATCH;
      end
      LATCH: begin
        busy      = 1'b1;
        state_nxt = (INSTR[8:4] == HALT_OP) ? HALTED : EXEC;
      end
      EXEC: begin
        busy = 1'b1;
        if (!STALL) state_nxt = WB;
      end
      WB: begin
        busy      = 1'b1;
        REG_WR_EN = !is_brh;
        state_nxt = FETCH;
      end
      HALTED: begin
        DONE = 1'b1;
        if (START) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_q  <= '0;
      tgt_q <= '0;
      ir_q  <= '0;
      br_q  <= 1'b0;
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (start_ok) begin
        pc_q  <= START_ADDRESS;
        cyc_q <= '0;
        ins_q <= '0;
      end
      if (state == LATCH) ir_q <= INSTR;
      // Branch decision is masked for non-branch opcodes so a stray BRANCH_TAKEN is harmless.
      if (state == EXEC && !STALL) begin
        br_q  <= BRANCH_TAKEN && is_brh;
        tgt_q <= TARGET;
      end
      if (state == WB) begin
        pc_q <= br_q ? tgt_q : pc_q + PC_W'(1);
        if (ins_q != '1) ins_q <= ins_q + CNT_W'(1);
      end
      if (busy && cyc_q != '1) cyc_q <= cyc_q + CNT_W'(1);
    end
  end

  assign PC          = pc_q;
  assign IR          = ir_q;
  assign BUSY        = busy;
  assign CYCLE_COUNT = cyc_q;
  assign INSTR_COUNT = ins_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a ROM model plus queues of expected fetch
// addresses and write-back instructions, checked as the DUT produces them.
module tb_instr_sequencer;
  import isa_defs_pkg::*;

  localparam int         PC_W = 8;
  localparam int         CW   = 5;
  localparam logic [4:0] HALT = 5'b11111;

  logic            clk = 1'b0;
  logic            reset, start, stall, branch_taken;
  logic [PC_W-1:0] start_address, target;
  logic [8:0]      instr;
  logic            imem_rd, reg_wr_en, busy, done;
  logic [PC_W-1:0] pc;
  logic [8:0]      ir;
  logic [CW-1:0]   cycle_count, instr_count;

  logic [8:0]      rom [256];
  logic [PC_W-1:0] exp_fetch_q [$];
  logic [8:0]      exp_wr_q [$];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instr_sequencer #(.PC_W(PC_W), .HALT_OP(HALT), .CNT_W(CW)) dut (
    .CLK(clk), .RESET(reset), .START(start), .START_ADDRESS(start_address),
    .INSTR(instr), .IMEM_RD(imem_rd), .PC(pc), .IR(ir), .STALL(stall),
    .BRANCH_TAKEN(branch_taken), .TARGET(target), .REG_WR_EN(reg_wr_en),
    .BUSY(busy), .DONE(done), .CYCLE_COUNT(cycle_count), .INSTR_COUNT(instr_count)
  );

  always @(posedge clk) if (imem_rd) instr <= rom[pc];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every fetch and every write strobe must match the next queued entry.
  always @(negedge clk) begin
    if (imem_rd === 1'b1) begin
      if (exp_fetch_q.size() == 0) chk("fetch_unexpected", {24'd0, pc}, 32'hDEAD);
      else chk("fetch_pc", {24'd0, pc}, {24'd0, exp_fetch_q.pop_front()});
    end
    if (reg_wr_en === 1'b1) begin
      if (exp_wr_q.size() == 0) chk("wr_unexpected", {23'd0, ir}, 32'hDEAD);
      else chk("wr_ir", {23'd0, ir}, {23'd0, exp_wr_q.pop_front()});
    end
  end

  function automatic logic [8:0] mk(input logic [4:0] op, input logic [1:0] a, input logic [1:0] b);
    return {op, a, b};
  endfunction

  function automatic logic [31:0] all_outs();
    return {1'b0, imem_rd, reg_wr_en, busy, done, pc, ir, cycle_count, instr_count};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_prog(input logic [PC_W-1:0] addr);
    start = 1'b1;
    start_address = addr;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    start_address = '0; target = '0;
    for (int i = 0; i < 256; i++) rom[i] = mk(HALT, 2'd0, 2'd0);

    // Reset: everything reads zero and stays idle
    step(2);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("reset_outs", all_outs(), 32'd0);
      step(1);
    end

    // Straight-line program
    rom[8'h10] = mk(kADD, 2'd1, 2'd2);
    rom[8'h11] = mk(kMOV, 2'd3, 2'd0);
    rom[8'h12] = mk(kAND, 2'd2, 2'd1);
    rom[8'h13] = mk(HALT, 2'd0, 2'd0);
    for (int a = 8'h10; a <= 8'h13; a++) exp_fetch_q.push_back(PC_W'(a));
    for (int a = 8'h10; a <= 8'h12; a++) exp_wr_q.push_back(rom[a]);
    start_prog(8'h10);
    chk("sl_fetch1", {29'd0, imem_rd, busy, done}, 32'b110);
    chk("sl_pc1", {24'd0, pc}, 32'h10);
    step(3);
    chk("sl_wr1", {31'd0, reg_wr_en}, 32'd1);
    step(1);
    chk("sl_wr1_width", {31'd0, reg_wr_en}, 32'd0);
    chk("sl_pc2", {24'd0, pc}, 32'h11);
    step(3);
    chk("sl_wr2", {31'd0, reg_wr_en}, 32'd1);
    step(4);
    chk("sl_wr3", {31'd0, reg_wr_en}, 32'd1);
    step(2);
    chk("sl_done_early", {30'd0, busy, done}, 32'b10);
    step(1);
    chk("sl_done", {30'd0, busy, done}, 32'b01);
    chk("sl_pc_end", {24'd0, pc}, 32'h13);
    chk("sl_instr_cnt", {27'd0, instr_count}, 32'd3);
    chk("sl_cycle_cnt", {27'd0, cycle_count}, 32'd14);
    chk("sl_ir_halt", {23'd0, ir}, {23'd0, mk(HALT, 2'd0, 2'd0)});
    step(3);
    chk("sl_halt_hold", {24'd0, pc}, 32'h13);

    // Taken branch on kBRH: no write, refetch at target
    rom[8'h20] = mk(kBRH, 2'd0, 2'd1);
    rom[8'h05] = mk(HALT, 2'd0, 2'd0);
    exp_fetch_q.push_back(8'h20);
    exp_fetch_q.push_back(8'h05);
    branch_taken = 1'b1; target = 8'h05;
    start_prog(8'h20);
    wait_done(40);
    chk("br_pc", {24'd0, pc}, 32'h05);
    chk("br_instr_cnt", {27'd0, instr_count}, 32'd1);
    chk("br_cycle_cnt", {27'd0, cycle_count}, 32'd6);

    // Spurious BRANCH_TAKEN on a non-branch
    rom[8'h20] = mk(kADD, 2'd2, 2'd2);
    rom[8'h21] = mk(HALT, 2'd0, 2'd0);
    exp_fetch_q.push_back(8'h20);
    exp_fetch_q.push_back(8'h21);
    exp_wr_q.push_back(rom[8'h20]);
    start_prog(8'h20);
    wait_done(40);
    chk("nobr_pc", {24'd0, pc}, 32'h21);
    branch_taken = 1'b0;

    // Three stall cycles in EXEC, plus a START that must be ignored
    rom[8'h40] = mk(kMOV, 2'd1, 2'd1);
    rom[8'h41] = mk(HALT, 2'd0, 2'd0);
    exp_fetch_q.push_back(8'h40);
    exp_fetch_q.push_back(8'h41);
    exp_wr_q.push_back(rom[8'h40]);
    stall = 1'b1;
    start_prog(8'h40);
    step(2);
    chk("st_ir_exec", {23'd0, ir}, {23'd0, rom[8'h40]});
    step(1);
    start = 1'b1; start_address = 8'h99;
    chk("st_no_wr_k4", {31'd0, reg_wr_en}, 32'd0);
    step(1);
    start = 1'b0;
    chk("st_busy", {31'd0, busy}, 32'd1);
    step(1);
    stall = 1'b0;
    chk("st_no_wr_k6", {31'd0, reg_wr_en}, 32'd0);
    step(1);
    chk("st_wr_k7", {31'd0, reg_wr_en}, 32'd1);
    chk("st_ir_wb", {23'd0, ir}, {23'd0, rom[8'h40]});
    step(1);
    chk("st_pc_next", {24'd0, pc}, 32'h41);
    wait_done(40);
    chk("st_cycle_cnt", {27'd0, cycle_count}, 32'd9);

    // PC wrap 0xFF -> 0x00
    rom[8'hFF] = mk(kAND, 2'd3, 2'd3);
    rom[8'h00] = mk(HALT, 2'd0, 2'd0);
    exp_fetch_q.push_back(8'hFF);
    exp_fetch_q.push_back(8'h00);
    exp_wr_q.push_back(rom[8'hFF]);
    start_prog(8'hFF);
    wait_done(40);
    chk("wrap_pc", {24'd0, pc}, 32'h00);

    // Reset during EXEC, colliding with START: abort, no write, stay idle
    rom[8'h60] = mk(kADD, 2'd1, 2'd0);
    exp_fetch_q.push_back(8'h60);
    start_prog(8'h60);
    step(2);
    chk("rst_in_exec", {31'd0, busy}, 32'd1);
    reset = 1'b1; start = 1'b1; start_address = 8'h10;
    step(1);
    reset = 1'b0; start = 1'b0;
    chk("rst_midop_outs", all_outs(), 32'd0);
    step(2);
    chk("rst_still_idle", all_outs(), 32'd0);
    for (int a = 8'h10; a <= 8'h13; a++) exp_fetch_q.push_back(PC_W'(a));
    for (int a = 8'h10; a <= 8'h12; a++) exp_wr_q.push_back(rom[a]);
    start_prog(8'h10);
    wait_done(40);
    chk("restart_instr_cnt", {27'd0, instr_count}, 32'd3);
    chk("restart_cycle_cnt", {27'd0, cycle_count}, 32'd14);

    // Tight branch-to-self loop drives both counters into saturation
    rom[8'h50] = mk(kBRH, 2'd0, 2'd0);
    branch_taken = 1'b1; target = 8'h50;
    for (int k = 1; k <= 142; k++) if (k % 4 == 1) exp_fetch_q.push_back(8'h50);
    start_prog(8'h50);
    step(19);
    chk("loop_cycle_k20", {27'd0, cycle_count}, 32'd19);
    chk("loop_instr_k20", {27'd0, instr_count}, 32'd4);
    step(12);
    chk("loop_cycle_max", {27'd0, cycle_count}, 32'd31);
    step(2);
    chk("loop_cycle_sat", {27'd0, cycle_count}, 32'd31);
    step(108);
    chk("loop_instr_sat", {27'd0, instr_count}, 32'd31);
    chk("loop_cycle_sat2", {27'd0, cycle_count}, 32'd31);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    branch_taken = 1'b0;
    chk("loop_reset_outs", all_outs(), 32'd0);

    step(2);
    chk("fetch_q_empty", exp_fetch_q.size(), 32'd0);
    chk("wr_q_empty", exp_wr_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
